// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEF_INSTR_BYTES = 4;
    localparam int DEF_RESET_VEC   = 0;

    typedef logic [31:0] instr_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Signal bundle between the fetch sequencer and the PC, hazard unit, imem and IF/ID.
// imem handshake: a request is open while imem_req=1 and completes on the rising
// edge where imem_ack=1; imem_ack/imem_rdata are ignored whenever imem_req=0.
interface fetch_ctrl_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] curr_addr;
    logic              stall;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    instr_t            imem_rdata;
    logic [ADDR_W-1:0] next_addr;
    logic              pc_write;
    instr_t            instr;
    logic              instr_valid;
    logic              flush;

    modport master (
        input  curr_addr, stall, branch_taken, branch_target, imem_ack, imem_rdata,
        output imem_req, imem_addr, next_addr, pc_write, instr, instr_valid, flush
    );

    modport slave (
        output curr_addr, stall, branch_taken, branch_target, imem_ack, imem_rdata,
        input  imem_req, imem_addr, next_addr, pc_write, instr, instr_valid, flush
    );
endinterface

// File: rtl/fetch_ctrl_redirect_latch.sv
// Holds a taken-branch target that arrived while a fetch was still outstanding.
module redirect_latch #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_set,
    input  logic [ADDR_W-1:0] i_target,
    input  logic              i_clear,
    output logic              o_pending,
    output logic [ADDR_W-1:0] o_target
);

    logic              r_pending;
    logic [ADDR_W-1:0] r_target;

    // A new redirect always overwrites an older one: newest target wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_target  <= '0;
        end else if (i_set) begin
            r_pending <= 1'b1;
            r_target  <= i_target;
        end else if (i_clear) begin
            r_pending <= 1'b0;
        end
    end

    assign o_pending = r_pending;
    assign o_target  = r_target;

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: drives imem requests and PC loads, delivers words to IF/ID,
// and handles stalls and branch redirects (including ones during an outstanding fetch).
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int INSTR_BYTES = DEF_INSTR_BYTES,
    parameter int RESET_VEC   = DEF_RESET_VEC
) (
    input  logic          clk,
    input  logic          rst,
    fetch_ctrl_if.master  bus,
    output state_t        o_state
);

    localparam logic [ADDR_W-1:0] RST_ADDR = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] INC      = ADDR_W'(INSTR_BYTES);

    state_t            r_state;
    state_t            w_state_n;
    instr_t            r_instr;
    instr_t            r_buf;
    logic              r_instr_valid;
    logic              r_flush;

    logic              w_req;
    logic              w_pc_write;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_valid_n;
    logic              w_flush_n;
    logic              w_take_mem;
    logic              w_take_buf;
    logic              w_load_buf;
    logic              w_pend_set;
    logic              w_pend_clear;
    logic              w_pending;
    logic [ADDR_W-1:0] w_pend_target;

    redirect_latch #(.ADDR_W(ADDR_W)) u_redirect (
        .clk       (clk),
        .rst       (rst),
        .i_set     (w_pend_set),
        .i_target  (bus.branch_target),
        .i_clear   (w_pend_clear),
        .o_pending (w_pending),
        .o_target  (w_pend_target)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_req        = 1'b0;
        w_pc_write   = 1'b0;
        w_next_addr  = RST_ADDR;
        w_valid_n    = 1'b0;
        w_flush_n    = 1'b0;
        w_take_mem   = 1'b0;
        w_take_buf   = 1'b0;
        w_load_buf   = 1'b0;
        w_pend_set   = 1'b0;
        w_pend_clear = 1'b0;

        unique case (r_state)
            BOOT: begin
                w_pc_write = 1'b1;
                w_state_n  = FETCH;
            end
            FETCH: begin
                w_req = 1'b1;
                if (bus.imem_ack) begin
                    if (bus.branch_taken || w_pending) begin
                        // Word belongs to the wrong path; drop it and redirect.
                        w_pc_write   = 1'b1;
                        w_next_addr  = bus.branch_taken ? bus.branch_target : w_pend_target;
                        w_pend_clear = 1'b1;
                        w_flush_n    = 1'b1;
                    end else if (bus.stall) begin
                        w_load_buf = 1'b1;
                        w_state_n  = HOLD;
                    end else begin
                        w_take_mem  = 1'b1;
                        w_valid_n   = 1'b1;
                        w_pc_write  = 1'b1;
                        w_next_addr = bus.curr_addr + INC;
                    end
                end else if (bus.branch_taken) begin
                    w_pend_set = 1'b1;
                end
            end
            HOLD: begin
                if (bus.branch_taken) begin
                    w_pc_write  = 1'b1;
                    w_next_addr = bus.branch_target;
                    w_flush_n   = 1'b1;
                    w_state_n   = FETCH;
                end else if (!bus.stall) begin
                    w_take_buf  = 1'b1;
                    w_valid_n   = 1'b1;
                    w_pc_write  = 1'b1;
                    w_next_addr = bus.curr_addr + INC;
                    w_state_n   = FETCH;
                end
            end
            default: begin
                w_state_n = BOOT;
            end
        endcase

        // Reset must silence the PC and memory immediately, not at the next edge.
        if (rst) begin
            w_req      = 1'b0;
            w_pc_write = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr       <= '0;
            r_buf         <= '0;
            r_instr_valid <= 1'b0;
            r_flush       <= 1'b0;
        end else begin
            r_instr_valid <= w_valid_n;
            r_flush       <= w_flush_n;
            if (w_take_mem) begin
                r_instr <= bus.imem_rdata;
            end else if (w_take_buf) begin
                r_instr <= r_buf;
            end
            if (w_load_buf) begin
                r_buf <= bus.imem_rdata;
            end
        end
    end

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = bus.curr_addr;
    assign bus.pc_write    = w_pc_write;
    assign bus.next_addr   = w_next_addr;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = r_instr_valid;
    assign bus.flush       = r_flush;
    assign o_state         = r_state;

endmodule
